// File: rtl/msx_port_pkg.sv
// Shared types and constants for the MSX pointer port block.
package msx_port_pkg;

    typedef enum logic [1:0] {
        PM_JOY     = 2'b00,
        PM_MOUSE   = 2'b01,
        PM_AUTO    = 2'b10,
        PM_JOY_ALT = 2'b11
    } port_mode_t;

    typedef enum logic [1:0] {
        NIB_XH = 2'd0,
        NIB_XL = 2'd1,
        NIB_YH = 2'd2,
        NIB_YL = 2'd3
    } nib_state_t;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

endpackage

// File: rtl/msx_mouse_nibbler.sv
// MSX mouse nibble sequencer for one joystick port: strobe edge detection,
// X/Y motion accumulators with read snapshot, and sequence timeout.
// MSX_MOUSE_ACCUM_EN: when defined, host deltas are summed with saturation;
// otherwise each host update overwrites the stored motion.
module msx_mouse_nibbler
    import msx_port_pkg::*;
#(
    parameter int TIMEOUT  = 100000,
    parameter int MOTION_W = 9
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       active,
    input  logic                       strobe_in,
    input  logic                       mouse_strobe,
    input  logic signed [MOTION_W-1:0] mouse_x,
    input  logic signed [MOTION_W-1:0] mouse_y,
    output logic [3:0]                 nib_p1,
    output logic                       vld_p1
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    function automatic logic signed [7:0] sat_delta(input logic signed [MOTION_W:0] v);
        logic signed [MOTION_W:0] hi;
        logic signed [MOTION_W:0] lo;
        hi = (MOTION_W + 1)'(SAT_MAX);
        lo = (MOTION_W + 1)'(SAT_MIN);
        if (v > hi) return 8'(SAT_MAX);
        if (v < lo) return 8'(SAT_MIN);
        return v[7:0];
    endfunction

`ifdef MSX_MOUSE_ACCUM_EN
    function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                  input logic signed [7:0] b);
        logic signed [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s > 9'(SAT_MAX)) return 8'(SAT_MAX);
        if (s < 9'(SAT_MIN)) return 8'(SAT_MIN);
        return s[7:0];
    endfunction
`endif

    nib_state_t               state_p1, state_nx;
    logic                     strobe_p0;
    logic                     edge_p0;
    logic [TO_W-1:0]          to_cnt;
    logic signed [MOTION_W:0] x_neg_p0, y_ext_p0;
    logic signed [7:0]        dx_p0, dy_p0;
    logic signed [7:0]        acc_x, acc_y, acc_x_nx, acc_y_nx;
    logic signed [7:0]        snap_x, snap_y;
    logic                     yl_clear;

    // X is mirrored on the MSX side, so it is negated in one extra bit first
    assign x_neg_p0 = -{mouse_x[MOTION_W-1], mouse_x};
    assign y_ext_p0 = {mouse_y[MOTION_W-1], mouse_y};
    assign dx_p0    = sat_delta(x_neg_p0);
    assign dy_p0    = sat_delta(y_ext_p0);
    assign edge_p0  = strobe_in ^ strobe_p0;
    assign yl_clear = edge_p0 && (state_p1 == NIB_YL);

    // Next nibble state: advance on each strobe edge, fall back to XH on timeout
    always_comb begin
        state_nx = state_p1;
        if (!active) begin
            state_nx = NIB_XH;
        end else if (edge_p0) begin
            case (state_p1)
                NIB_XH:  state_nx = NIB_XL;
                NIB_XL:  state_nx = NIB_YH;
                NIB_YH:  state_nx = NIB_YL;
                default: state_nx = NIB_XH;
            endcase
        end else if (to_cnt == TO_W'(1)) begin
            state_nx = NIB_XH;
        end
    end

    // Next accumulator value: a finished frame clears before the new delta lands
    always_comb begin
        acc_x_nx = yl_clear ? 8'sd0 : acc_x;
        acc_y_nx = yl_clear ? 8'sd0 : acc_y;
        if (mouse_strobe) begin
`ifdef MSX_MOUSE_ACCUM_EN
            acc_x_nx = sat_add(acc_x_nx, dx_p0);
            acc_y_nx = sat_add(acc_y_nx, dy_p0);
`else
            acc_x_nx = dx_p0;
            acc_y_nx = dy_p0;
`endif
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_p1 <= NIB_XH;
        else          state_p1 <= state_nx;
    end

    // Edge register, timeout, accumulators and snapshot
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strobe_p0 <= 1'b0;
            to_cnt    <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            snap_x    <= '0;
            snap_y    <= '0;
            vld_p1    <= 1'b0;
        end else begin
            strobe_p0 <= strobe_in;
            if (!active) begin
                to_cnt <= '0;
                acc_x  <= '0;
                acc_y  <= '0;
                snap_x <= '0;
                snap_y <= '0;
                vld_p1 <= 1'b0;
            end else begin
                if (edge_p0)             to_cnt <= TO_W'(TIMEOUT);
                else if (to_cnt != '0)   to_cnt <= to_cnt - TO_W'(1);
                if (edge_p0)             vld_p1 <= 1'b1;
                if (edge_p0 && state_p1 == NIB_XH) begin
                    snap_x <= acc_x;
                    snap_y <= acc_y;
                end
                acc_x <= acc_x_nx;
                acc_y <= acc_y_nx;
            end
        end
    end

    // Nibble presented on each edge; XH reads live data, the rest the snapshot
    always_ff @(posedge clk_sys) begin
        if (edge_p0) begin
            case (state_p1)
                NIB_XH:  nib_p1 <= acc_x[7:4];
                NIB_XL:  nib_p1 <= snap_x[3:0];
                NIB_YH:  nib_p1 <= snap_y[7:4];
                default: nib_p1 <= snap_y[3:0];
            endcase
        end
    end

endmodule

// File: rtl/msx_pointer_port.sv
// MSX joystick-port front end: per-port joystick pass-through or mouse
// nibble protocol, with host mouse data routed to the port on mouse_sel.
// MSX_MOUSE_ACCUM_EN selects accumulating versus overwriting motion storage.
module msx_pointer_port
    import msx_port_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int TIMEOUT  = 100000,
    parameter int MOTION_W = 9,
    localparam int SEL_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [NPORTS*6-1:0]        joy_in,
    input  logic [NPORTS-1:0]          strobe_in,
    input  logic [NPORTS*2-1:0]        mode,
    input  logic [SEL_W-1:0]           mouse_sel,
    input  logic                       mouse_strobe,
    input  logic signed [MOTION_W-1:0] mouse_x,
    input  logic signed [MOTION_W-1:0] mouse_y,
    input  logic [1:0]                 mouse_btn,
    output logic [NPORTS*6-1:0]        port_out,
    output logic [NPORTS-1:0]          mouse_active
);

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        port_mode_t pm;
        logic       sel;
        logic       act_p1;
        logic       vld_p1;
        logic [3:0] nib_p1;
        logic [5:0] joy_w;
        logic [5:0] port_p2;

        assign pm    = port_mode_t'(mode[2*i +: 2]);
        assign sel   = (mouse_sel == SEL_W'(i));
        assign joy_w = joy_in[6*i +: 6];

        // Mouse ownership: forced in mouse mode, host-claimed in auto mode
        // until the joystick pulls any line low (release beats claim)
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                act_p1 <= 1'b0;
            end else if (!sel) begin
                act_p1 <= 1'b0;
            end else begin
                case (pm)
                    PM_MOUSE: act_p1 <= 1'b1;
                    PM_AUTO: begin
                        if (!(&joy_w))     act_p1 <= 1'b0;
                        else if (mouse_strobe) act_p1 <= 1'b1;
                    end
                    default:  act_p1 <= 1'b0;
                endcase
            end
        end

        msx_mouse_nibbler #(
            .TIMEOUT  (TIMEOUT),
            .MOTION_W (MOTION_W)
        ) u_nibbler (
            .clk_sys      (clk_sys),
            .reset_n      (reset_n),
            .active       (act_p1),
            .strobe_in    (strobe_in[i]),
            .mouse_strobe (mouse_strobe & sel),
            .mouse_x      (mouse_x),
            .mouse_y      (mouse_y),
            .nib_p1       (nib_p1),
            .vld_p1       (vld_p1)
        );

        // Output register: mouse buttons and nibble, or joystick gated by strobe
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n)    port_p2 <= '1;
            else if (act_p1) port_p2 <= {~mouse_btn, vld_p1 ? nib_p1 : 4'hF};
            else             port_p2 <= joy_w | {6{strobe_in[i]}};
        end

        assign port_out[6*i +: 6] = port_p2;
        assign mouse_active[i]    = act_p1;
    end

endmodule

// File: tb/tb_msx_pointer_port.sv
// Directed testbench for msx_pointer_port (two ports, short timeout).
module tb_msx_pointer_port;

    localparam int NPORTS   = 2;
    localparam int TIMEOUT  = 20;
    localparam int MOTION_W = 9;

`ifdef MSX_MOUSE_ACCUM_EN
    localparam logic [7:0] SAT_X = 8'h80;
`else
    localparam logic [7:0] SAT_X = 8'h9C;
`endif

    logic                       clk_sys = 1'b0;
    logic                       reset_n;
    logic [NPORTS*6-1:0]        joy_in;
    logic [NPORTS-1:0]          strobe_in;
    logic [NPORTS*2-1:0]        mode;
    logic [0:0]                 mouse_sel;
    logic                       mouse_strobe;
    logic signed [MOTION_W-1:0] mouse_x;
    logic signed [MOTION_W-1:0] mouse_y;
    logic [1:0]                 mouse_btn;
    logic [NPORTS*6-1:0]        port_out;
    logic [NPORTS-1:0]          mouse_active;

    int n_cmp = 0;
    int n_bad = 0;

    msx_pointer_port #(
        .NPORTS   (NPORTS),
        .TIMEOUT  (TIMEOUT),
        .MOTION_W (MOTION_W)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .joy_in       (joy_in),
        .strobe_in    (strobe_in),
        .mode         (mode),
        .mouse_sel    (mouse_sel),
        .mouse_strobe (mouse_strobe),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_btn    (mouse_btn),
        .port_out     (port_out),
        .mouse_active (mouse_active)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_mouse(input logic signed [MOTION_W-1:0] x,
                               input logic signed [MOTION_W-1:0] y);
        mouse_x = x;
        mouse_y = y;
        mouse_strobe = 1'b1;
        tick(1);
        mouse_strobe = 1'b0;
    endtask

    // Flip port 0 strobe, optionally with a coincident host update, then wait
    // the two cycles for the nibble to reach port_out.
    task automatic toggle0(input logic with_mouse, input logic signed [MOTION_W-1:0] x);
        strobe_in[0] = ~strobe_in[0];
        if (with_mouse) begin
            mouse_x = x;
            mouse_y = '0;
            mouse_strobe = 1'b1;
        end
        tick(1);
        mouse_strobe = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        joy_in = '1; strobe_in = '0; mode = '0; mouse_sel = '0;
        mouse_strobe = 1'b0; mouse_x = '0; mouse_y = '0; mouse_btn = '0;
        tick(3);
        n_cmp++; if (port_out !== 12'hFFF) begin n_bad++; $display("FAIL reset_port_out: got %h expected %h", port_out, 12'hFFF); end
        n_cmp++; if (mouse_active !== 2'b00) begin n_bad++; $display("FAIL reset_active: got %b expected %b", mouse_active, 2'b00); end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_joystick;
        joy_in = {6'b010101, 6'b101010};
        strobe_in = 2'b00;
        tick(1);
        n_cmp++; if (port_out !== {6'b010101, 6'b101010}) begin n_bad++; $display("FAIL joy_pass: got %b expected %b", port_out, {6'b010101, 6'b101010}); end
        strobe_in = 2'b10;
        tick(1);
        n_cmp++; if (port_out !== {6'b111111, 6'b101010}) begin n_bad++; $display("FAIL joy_strobe: got %b expected %b", port_out, {6'b111111, 6'b101010}); end
        mode = 4'b0100;
        strobe_in = 2'b00;
        tick(2);
        n_cmp++; if (port_out !== {6'b010101, 6'b101010}) begin n_bad++; $display("FAIL joy_unsel_mouse: got %b expected %b", port_out, {6'b010101, 6'b101010}); end
        n_cmp++; if (mouse_active !== 2'b00) begin n_bad++; $display("FAIL unsel_active: got %b expected %b", mouse_active, 2'b00); end
    endtask

    task automatic test_nibbles;
        logic [3:0] exp_nib [4];
        logic [3:0] prev;
        exp_nib = '{4'hF, 4'hB, 4'h0, 4'h3};
        joy_in = '1;
        mode = 4'b0001;
        strobe_in = 2'b00;
        tick(2);
        n_cmp++; if (mouse_active !== 2'b01) begin n_bad++; $display("FAIL mouse_active_on: got %b expected %b", mouse_active, 2'b01); end
        n_cmp++; if (port_out[5:0] !== 6'h3F) begin n_bad++; $display("FAIL idle_nibble: got %h expected %h", port_out[5:0], 6'h3F); end
        mouse_btn = 2'b01;
        pulse_mouse(9'sd5, 9'sd3);
        n_cmp++; if (port_out[5:4] !== 2'b10) begin n_bad++; $display("FAIL buttons: got %b expected %b", port_out[5:4], 2'b10); end
        prev = 4'hF;
        for (int k = 0; k < 4; k++) begin
            strobe_in[0] = ~strobe_in[0];
            tick(1);
            n_cmp++; if (port_out[3:0] !== prev) begin n_bad++; $display("FAIL nib_latency%0d: got %h expected %h", k, port_out[3:0], prev); end
            tick(1);
            n_cmp++; if (port_out[3:0] !== exp_nib[k]) begin n_bad++; $display("FAIL nib%0d: got %h expected %h", k, port_out[3:0], exp_nib[k]); end
            prev = exp_nib[k];
        end
    endtask

    task automatic test_saturation_timeout;
        repeat (3) begin
            pulse_mouse(9'sd100, 9'sd0);
            tick(1);
        end
        toggle0(1'b0, '0);
        n_cmp++; if (port_out[3:0] !== SAT_X[7:4]) begin n_bad++; $display("FAIL sat_xh: got %h expected %h", port_out[3:0], SAT_X[7:4]); end
        toggle0(1'b0, '0);
        n_cmp++; if (port_out[3:0] !== SAT_X[3:0]) begin n_bad++; $display("FAIL sat_xl: got %h expected %h", port_out[3:0], SAT_X[3:0]); end
        tick(TIMEOUT + 2);
        toggle0(1'b0, '0);
        n_cmp++; if (port_out[3:0] !== SAT_X[7:4]) begin n_bad++; $display("FAIL timeout_xh: got %h expected %h", port_out[3:0], SAT_X[7:4]); end
        tick(TIMEOUT + 2);
    endtask

    task automatic test_tear_and_clear;
        logic [3:0] exp_tail [4];
        exp_tail = '{4'h0, 4'h2, 4'h0, 4'h0};
        toggle0(1'b0, '0);
        n_cmp++; if (port_out[3:0] !== SAT_X[7:4]) begin n_bad++; $display("FAIL tear_xh: got %h expected %h", port_out[3:0], SAT_X[7:4]); end
        pulse_mouse(-9'sd50, 9'sd7);
        toggle0(1'b0, '0);
        n_cmp++; if (port_out[3:0] !== SAT_X[3:0]) begin n_bad++; $display("FAIL tear_xl: got %h expected %h", port_out[3:0], SAT_X[3:0]); end
        toggle0(1'b0, '0);
        n_cmp++; if (port_out[3:0] !== 4'h0) begin n_bad++; $display("FAIL tear_yh: got %h expected %h", port_out[3:0], 4'h0); end
        toggle0(1'b1, -9'sd2);
        n_cmp++; if (port_out[3:0] !== 4'h0) begin n_bad++; $display("FAIL tear_yl: got %h expected %h", port_out[3:0], 4'h0); end
        for (int k = 0; k < 4; k++) begin
            toggle0(1'b0, '0);
            n_cmp++; if (port_out[3:0] !== exp_tail[k]) begin n_bad++; $display("FAIL yl_clear%0d: got %h expected %h", k, port_out[3:0], exp_tail[k]); end
        end
    endtask

    task automatic test_auto;
        mode = 4'b0000;
        strobe_in = 2'b00;
        joy_in = '1;
        tick(2);
        n_cmp++; if (mouse_active[0] !== 1'b0) begin n_bad++; $display("FAIL auto_off: got %b expected %b", mouse_active[0], 1'b0); end
        mode = 4'b0010;
        tick(2);
        n_cmp++; if (mouse_active[0] !== 1'b0) begin n_bad++; $display("FAIL auto_idle: got %b expected %b", mouse_active[0], 1'b0); end
        pulse_mouse(9'sd0, 9'sd0);
        n_cmp++; if (mouse_active[0] !== 1'b1) begin n_bad++; $display("FAIL auto_claim: got %b expected %b", mouse_active[0], 1'b1); end
        joy_in[5:0] = 6'b111110;
        tick(1);
        n_cmp++; if (mouse_active[0] !== 1'b0) begin n_bad++; $display("FAIL auto_release: got %b expected %b", mouse_active[0], 1'b0); end
        tick(1);
        n_cmp++; if (port_out[5:0] !== 6'b111110) begin n_bad++; $display("FAIL auto_joy_out: got %b expected %b", port_out[5:0], 6'b111110); end
        pulse_mouse(9'sd0, 9'sd0);
        n_cmp++; if (mouse_active[0] !== 1'b0) begin n_bad++; $display("FAIL auto_clear_wins: got %b expected %b", mouse_active[0], 1'b0); end
    endtask

    task automatic test_reset_mid;
        joy_in = '1;
        mode = 4'b0001;
        strobe_in = 2'b00;
        tick(2);
        pulse_mouse(9'sd1, 9'sd1);
        toggle0(1'b0, '0);
        toggle0(1'b0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (port_out !== 12'hFFF) begin n_bad++; $display("FAIL async_reset_out: got %h expected %h", port_out, 12'hFFF); end
        n_cmp++; if (mouse_active !== 2'b00) begin n_bad++; $display("FAIL async_reset_active: got %b expected %b", mouse_active, 2'b00); end
        tick(1);
        reset_n = 1'b1;
        tick(1);
        pulse_mouse(9'sd5, 9'sd0);
        toggle0(1'b0, '0);
        n_cmp++; if (port_out[3:0] !== 4'hF) begin n_bad++; $display("FAIL post_reset_xh: got %h expected %h", port_out[3:0], 4'hF); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_joystick();
        test_nibbles();
        test_saturation_timeout();
        test_tear_and_clear();
        test_auto();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
